// File: rtl/sqrt_pkg.sv
// Shared state codes for the square-root sequencer and its output decode.
package sqrt_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD  = 4'd1,
    ST_INIT1 = 4'd2,
    ST_INIT2 = 4'd3,
    ST_INIT3 = 4'd4,
    ST_BODY1 = 4'd5,
    ST_BODY2 = 4'd6,
    ST_BODY3 = 4'd7,
    ST_BODY4 = 4'd8,
    ST_BODY5 = 4'd9,
    ST_BODY6 = 4'd10,
    ST_BODY7 = 4'd11,
    ST_TEST  = 4'd12,
    ST_DONE  = 4'd13
  } state_t;

  // Busy covers every state that is neither parked in IDLE nor waiting in DONE.
  function automatic logic is_busy(input state_t s);
    return !((s == ST_IDLE) || (s == ST_DONE));
  endfunction

endpackage

// File: rtl/sqrt_iter_cnt.sv
// Saturating iteration counter; the limit compare exists only when
// SQRT_SEQ_ITER_LIMIT_EN is defined.
module sqrt_iter_cnt #(
  parameter int unsigned MAX_ITER = 16,
  parameter int unsigned ITER_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [ITER_W-1:0] cnt
`ifdef SQRT_SEQ_ITER_LIMIT_EN
  ,
  output logic              limit_hit_c
`endif
);

  if ((MAX_ITER < 1) || (MAX_ITER >= (1 << ITER_W))) begin : g_bad_max_iter
    $error("sqrt_iter_cnt: MAX_ITER outside 1..2^ITER_W-1");
  end

  logic [ITER_W-1:0] cnt_inc;

  // Post-increment value, pinned at all-ones once saturated.
  assign cnt_inc = (&cnt) ? cnt : ITER_W'(cnt + ITER_W'(1));

`ifdef SQRT_SEQ_ITER_LIMIT_EN
  assign limit_hit_c = (cnt_inc == ITER_W'(MAX_ITER));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/sqrt_sequencer.sv
// Square-root datapath sequencer: init phase, iteration loop, result handshake.
// Optional iteration limit compiled in with SQRT_SEQ_ITER_LIMIT_EN.
module sqrt_sequencer
  import sqrt_pkg::*;
#(
  parameter int unsigned MAX_ITER = 16,
  parameter int unsigned ITER_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              loop_cont,
  input  logic              ack,
  input  logic              stall,
  output logic [3:0]        state,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              err
);

  state_t state_q;
  state_t state_d;
  logic   err_d;
  logic   cnt_clr;
  logic   cnt_en;
`ifdef SQRT_SEQ_ITER_LIMIT_EN
  logic   limit_hit_c;
`endif

  sqrt_iter_cnt #(
    .MAX_ITER (MAX_ITER),
    .ITER_W   (ITER_W)
  ) u_iter_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr         (cnt_clr),
    .en          (cnt_en),
    .cnt         (iter_cnt)
`ifdef SQRT_SEQ_ITER_LIMIT_EN
    ,
    .limit_hit_c (limit_hit_c)
`endif
  );

  // State and status registers; busy/done track the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= is_busy(state_d);
      done    <= (state_d == ST_DONE);
      err     <= err_d;
    end
  end

  assign state = state_q;

  // Next-state logic; illegal codes 14/15 fall into default and recover to IDLE.
  always_comb begin
    state_d = state_q;
    err_d   = err;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          err_d   = 1'b0;
          cnt_clr = 1'b1;
        end
      end
      ST_LOAD, ST_INIT1, ST_INIT2, ST_INIT3,
      ST_BODY1, ST_BODY2, ST_BODY3, ST_BODY4,
      ST_BODY5, ST_BODY6, ST_BODY7: begin
        if (!stall) begin
          state_d = state_t'(STATE_W'(state_q + STATE_W'(1)));
        end
      end
      ST_TEST: begin
        if (!stall) begin
          cnt_en = 1'b1;
`ifdef SQRT_SEQ_ITER_LIMIT_EN
          if (limit_hit_c) begin
            state_d = ST_DONE;
            if (loop_cont) begin
              err_d = 1'b1;
            end
          end else
`endif
          if (loop_cont) begin
            state_d = ST_BODY1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/sqrt_sequencer.md
# sqrt_sequencer

Sequencing controller for the square-root datapath. Holds the 4-bit control state `state[3:0]` consumed by the existing output-decode logic, which drives the register enables, bus selects and AU function selects. It walks the init phase and the iteration loop. It accepts a start handshake, evaluates the datapath loop-continue flag and holds the result phase until acknowledged. It sits between the host/handshake layer and the datapath control decode.

## Interface
- `MAX_ITER`, default 16: iteration limit, used only when the limit feature is compiled in; legal range 1..2^ITER_W-1.
- `ITER_W`, default 5: iteration counter width.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: request a new computation; sampled only in IDLE.
- `loop_cont`  in  1: datapath flag, 1 = another iteration is required; sampled only in TEST.
- `ack`  in  1: result consumed; sampled only in DONE.
- `stall`  in  1: freezes state and counter for the cycle; ignored in IDLE and DONE.
- `state`  out  4: registered control state fed to the output decode.
- `busy`  out  1: high in every state except IDLE and DONE.
- `done`  out  1: high in DONE, registered with the state.
- `iter_cnt`  out  ITER_W: completed iterations of the current run.
- `err`  out  1: sticky error flag; cleared by `rst` or by an accepted `start`.

## Operation
- State encoding (decimal): IDLE=0, LOAD=1, INIT1..INIT3=2..4, BODY1..BODY7=5..11, TEST=12, DONE=13. Codes 14 and 15 are illegal.
- IDLE, `start`=1: go to LOAD, clear `iter_cnt` and `err`. With `start`=0, stay in IDLE.
- States 1..11: advance by +1 per cycle unless `stall`=1.
- TEST (no stall): increment `iter_cnt` (saturating at all-ones).
  - `loop_cont`=1: go to BODY1.
  - `loop_cont`=0: go to DONE.
- DONE: hold until `ack`=1, then go to IDLE. `start` is ignored in DONE.
- Illegal state (14/15): go to IDLE on the next cycle and set `err`=1. Code 15 also decodes as Done downstream, so it must never persist for more than one cycle.
- `stall` in TEST holds TEST; `loop_cont` is re-sampled on the first non-stalled TEST cycle.
- Simultaneous events:
  - `start` with `stall` in IDLE: `start` wins, since `stall` is ignored there.
  - `ack` with `start` in DONE: only `ack` acts. `start` is honoured from IDLE one cycle later.

## Timing
- Reset values: `state`=0, `busy`=0, `done`=0, `iter_cnt`=0, `err`=0.
- `rst` mid-run forces all of the above on the next edge, regardless of other inputs.
- `start` accepted at edge k gives LOAD at k+1 and the first TEST at k+12.
- With no stalls and N iterations, DONE is reached at k+5+8N. For N=1 that is k+13.
- Each stall cycle adds exactly one cycle of latency.
- `done` falls on the edge after `ack` is sampled high. The earliest next LOAD is one cycle later.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SQRT_SEQ_ITER_LIMIT_EN` defined:
  - In TEST, if the post-increment `iter_cnt` equals `MAX_ITER`, go to DONE regardless of `loop_cont`.
  - If `loop_cont` was 1 at that point, set `err`=1.
- Not defined: the loop exits only on `loop_cont`=0, and `err` is set only by illegal states.

## Structure
- Shared package `sqrt_pkg`: the state-code constants `ST_IDLE`..`ST_DONE` and a 4-bit state typedef. The output-decode block uses the same codes.
- One sub-module, `sqrt_iter_cnt`:
  - contains the saturating ITER_W counter with clear/enable;
  - contains the limit compare, present only under the macro.
- FSM and output registers live in the top module.

## Test plan
- Reset: `rst`=1 for 2 cycles mid-run (state 7) -> next cycle `state`=0, `busy`=0, `done`=0, `iter_cnt`=0.
- Single iteration: `start` pulse at cycle 0, `loop_cont`=0 -> states 1..12 on consecutive cycles, `done`=1 at cycle 13, `iter_cnt`=1. `ack` at cycle 15 -> `state`=0 at cycle 16.
- Three iterations plus one stall: `loop_cont`=1,1,0 and one `stall` cycle in BODY3 -> `done` at cycle 5+24+1=30, `iter_cnt`=3.
- Handshake edges:
  - `start` held high in DONE with `ack`=0 -> stays in DONE.
  - `ack` and `start` both high in DONE -> IDLE, then LOAD on the following cycle.
- Illegal state: force `state`=14 -> IDLE next cycle, `err`=1; the next accepted `start` clears `err`.
- Limit (macro on, `MAX_ITER`=4): `loop_cont` stuck at 1 -> DONE after the 4th TEST, `iter_cnt`=4, `err`=1. Macro off: the loop continues past 4 iterations.
